// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin arbiter sharing the async FIFO write port among NUM_REQ requesters
// Macro FIFO_ARB_BURST_EN: grants last up to BURST_LEN beats; undefined gives one beat per grant.

module fifo_write_arbiter #(
   parameter int DSIZE     = 8,
   parameter int NUM_REQ   = 4,
   parameter int BURST_LEN = 4
) (
   input  logic                       wclk,
   input  logic                       wrst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*DSIZE-1:0]   req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic                       wfull,
   output logic                       winc,
   output logic [DSIZE-1:0]           wdata,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy
);

   localparam int GW = $clog2(NUM_REQ);
   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_GRANT = 1'b1;

   logic [0:0]    r_state;
   logic [GW-1:0] r_gnt;
   logic [GW-1:0] r_rr_ptr;

   logic          w_in_grant;
   logic          w_can_write;
   logic          w_sel_valid;
   logic          w_accept;
   logic          w_last;
   logic          w_release;
   logic          w_found;
   logic [GW-1:0] w_pick;
   logic [GW:0]   w_sum;
   logic [GW-1:0] w_gnt_next;

   // Scan upward from rr_ptr; w_sum has one spare bit so the wrap is a single subtract.
   always_comb begin
      w_found = 1'b0;
      w_pick  = r_rr_ptr;
      w_sum   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_sum = {1'b0, r_rr_ptr} + (GW+1)'(k);
         if (w_sum >= (GW+1)'(NUM_REQ)) begin
            w_sum = w_sum - (GW+1)'(NUM_REQ);
         end
         if (!w_found && req_valid[w_sum[GW-1:0]]) begin
            w_found = 1'b1;
            w_pick  = w_sum[GW-1:0];
         end
      end
   end

   assign w_gnt_next  = (r_gnt == GW'(NUM_REQ-1)) ? '0 : r_gnt + GW'(1);
   assign w_in_grant  = (r_state == S_GRANT);
   assign w_can_write = w_in_grant & ~wfull & wrst_n;
   assign w_sel_valid = req_valid[r_gnt];
   assign w_accept    = w_can_write & w_sel_valid;

`ifdef FIFO_ARB_BURST_EN
   localparam int BC_W = $clog2(BURST_LEN) + 1;
   logic [BC_W-1:0] r_beat_cnt;
   assign w_last = (r_beat_cnt == BC_W'(BURST_LEN-1));
`else
   // Single-beat grants: every accepted beat is the last, whatever BURST_LEN says.
   assign w_last = (BURST_LEN > 0);
`endif

   // A dropped valid releases even while wfull stalls the grant.
   assign w_release = w_in_grant & ((w_accept & w_last) | ~w_sel_valid);

   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         r_state    <= S_IDLE;
         r_gnt      <= '0;
         r_rr_ptr   <= '0;
`ifdef FIFO_ARB_BURST_EN
         r_beat_cnt <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_state    <= S_GRANT;
                  r_gnt      <= w_pick;
`ifdef FIFO_ARB_BURST_EN
                  r_beat_cnt <= '0;
`endif
               end
            end
            default: begin
               if (w_release) begin
                  r_state  <= S_IDLE;
                  r_rr_ptr <= w_gnt_next;
               end
`ifdef FIFO_ARB_BURST_EN
               else if (w_accept) begin
                  r_beat_cnt <= r_beat_cnt + BC_W'(1);
               end
`endif
            end
         endcase
      end
   end

   assign req_ready = w_can_write ? (NUM_REQ'(1) << r_gnt) : '0;
   assign winc      = w_accept;
   assign wdata     = w_in_grant ? req_data[r_gnt*DSIZE +: DSIZE] : '0;
   assign grant_id  = r_gnt;
   assign busy      = w_in_grant;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - directed scoreboard bench for fifo_write_arbiter
// Covers both builds of FIFO_ARB_BURST_EN.

module tb_fifo_write_arbiter;

   localparam int DSIZE     = 8;
   localparam int NUM_REQ   = 4;
   localparam int BURST_LEN = 4;
`ifdef FIFO_ARB_BURST_EN
   localparam int EFF = BURST_LEN;
`else
   localparam int EFF = 1;
`endif
   // Writes in the 20 cycles starting at the first grant with all requesters valid.
   localparam int NW = 20 * EFF / (EFF + 1);

   logic                     wclk = 1'b0;
   logic                     wrst_n;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*DSIZE-1:0] req_data;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     wfull;
   logic                     winc;
   logic [DSIZE-1:0]         wdata;
   logic [1:0]               grant_id;
   logic                     busy;

   fifo_write_arbiter #(
      .DSIZE     (DSIZE),
      .NUM_REQ   (NUM_REQ),
      .BURST_LEN (BURST_LEN)
   ) dut (
      .wclk      (wclk),
      .wrst_n    (wrst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .wfull     (wfull),
      .winc      (winc),
      .wdata     (wdata),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   always #5 wclk = ~wclk;

   int         checks   = 0;
   int         errors   = 0;
   int         n_writes = 0;
   int         w0;
   int         ncyc;
   logic [3:0] cnt  [NUM_REQ];
   logic [3:0] ecnt [NUM_REQ];
   logic [9:0] exp_q [$];
   logic [9:0] e;

   logic               s_winc;
   logic [NUM_REQ-1:0] s_ready;
   logic               s_busy;
   logic [1:0]         s_gid;
   logic [DSIZE-1:0]   s_wdata;
   logic               eb;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic pack();
      for (int i = 0; i < NUM_REQ; i++) req_data[i*DSIZE +: DSIZE] = {4'(i), cnt[i]};
   endtask

   task automatic push(input int id);
      exp_q.push_back({2'(id), 4'(id), ecnt[id]});
      ecnt[id] = ecnt[id] + 4'd1;
   endtask

   // Sample on the falling edge, advance requester data after the rising edge.
   task automatic tick();
      logic [NUM_REQ-1:0] acc;
      @(negedge wclk);
      s_winc  = winc;
      s_ready = req_ready;
      s_busy  = busy;
      s_gid   = grant_id;
      s_wdata = wdata;
      if (wfull) check("no_write_when_full", 32'(winc), 32'(0));
      if (winc) begin
         n_writes++;
         checks++;
         assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_write observed id %0d data 0x%0h expected no write", grant_id, wdata);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("write_id_data", 32'({grant_id, wdata}), 32'(e));
         end
      end
      acc = req_ready & req_valid;
      @(posedge wclk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) if (acc[i]) cnt[i] = cnt[i] + 4'd1;
      pack();
   endtask

   task automatic do_reset();
      req_valid = '0;
      wfull     = 1'b0;
      wrst_n    = 1'b0;
      repeat (2) tick();
      wrst_n    = 1'b1;
   endtask

   initial begin
      wrst_n    = 1'b0;
      req_valid = 4'b1111;
      wfull     = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cnt[i]  = '0;
         ecnt[i] = '0;
      end
      pack();

      // Reset held with every requester valid
      repeat (3) begin
         tick();
         check("rst_winc", 32'(s_winc), 32'(0));
         check("rst_ready", 32'(s_ready), 32'(0));
      end
      check("rst_busy", 32'(s_busy), 32'(0));
      check("rst_gid", 32'(s_gid), 32'(0));
      check("rst_wdata", 32'(s_wdata), 32'(0));
      wrst_n = 1'b1;

      // Round-robin fairness
      for (int n = 0; n < NW + 1; n++) push((n / EFF) % NUM_REQ);
      tick();
      check("lat_idle_busy", 32'(s_busy), 32'(0));
      check("lat_idle_winc", 32'(s_winc), 32'(0));
      w0 = n_writes;
      tick();
      check("first_grant_id", 32'(s_gid), 32'(0));
      check("first_grant_winc", 32'(s_winc), 32'(1));
      repeat (19) tick();
      check("rr_writes_20cyc", 32'(n_writes - w0), 32'(NW));
      tick();
      check("rr_next_busy", 32'(s_busy), 32'(1));
      check("rr_next_gid", 32'(s_gid), 32'((NW / EFF) % NUM_REQ));
      check("rr_sb_empty", 32'(exp_q.size()), 32'(0));
      do_reset();

      // wfull stall on requester 2
      repeat (4) push(2);
      req_valid = 4'b0100;
      tick();
      tick();
      check("stall_beat1", 32'(s_winc), 32'(1));
      wfull = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         eb = (EFF > 1) || (k > 0);
         check("stall_winc", 32'(s_winc), 32'(0));
         check("stall_ready2", 32'(s_ready[2]), 32'(0));
         check("stall_busy", 32'(s_busy), 32'(eb));
         check("stall_gid", 32'(s_gid), 32'(2));
         check("stall_wdata", 32'(s_wdata), eb ? 32'({4'd2, cnt[2]}) : 32'(0));
      end
      wfull = 1'b0;
      ncyc  = 0;
      while (exp_q.size() != 0 && ncyc < 40) begin
         tick();
         ncyc++;
      end
      req_valid = '0;
      check("stall_drain_cycles", 32'(ncyc), 32'(3 + 2 / EFF));
      do_reset();

      // Valid drop releases the grant and still rotates priority
      push(3);
      req_valid = 4'b0010;
      tick();
      check("drop_idle_busy", 32'(s_busy), 32'(0));
      req_valid = 4'b1000;
      tick();
      check("drop_grant_busy", 32'(s_busy), 32'(1));
      check("drop_grant_gid", 32'(s_gid), 32'(1));
      check("drop_grant_winc", 32'(s_winc), 32'(0));
      tick();
      check("drop_bubble_busy", 32'(s_busy), 32'(0));
      tick();
      check("drop_next_gid", 32'(s_gid), 32'(3));
      check("drop_next_winc", 32'(s_winc), 32'(1));
      req_valid = '0;
      tick();
      do_reset();

`ifdef FIFO_ARB_BURST_EN
      // Early release after two beats of requester 1
      push(1);
      push(1);
      push(3);
      req_valid = 4'b1010;
      repeat (3) tick();
      req_valid = 4'b1000;
      tick();
      check("early_rel_busy", 32'(s_busy), 32'(1));
      check("early_rel_winc", 32'(s_winc), 32'(0));
      tick();
      check("early_idle_busy", 32'(s_busy), 32'(0));
      tick();
      check("early_next_gid", 32'(s_gid), 32'(3));
      check("early_next_winc", 32'(s_winc), 32'(1));
      req_valid = '0;
      tick();
      do_reset();
`else
      // Single-beat grants alternate between two requesters
      push(0);
      push(1);
      push(0);
      push(1);
      req_valid = 4'b0011;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("alt_winc", 32'(s_winc), 32'(k % 2));
      end
      req_valid = '0;
      tick();
      do_reset();
`endif

      // Reset on beat 3 of requester 1
      for (int n = 0; n < ((EFF >= 2) ? 2 : 1); n++) push(1);
      req_valid = 4'b0010;
      repeat (3) tick();
      wrst_n = 1'b0;
      tick();
      check("mid_rst_winc", 32'(s_winc), 32'(0));
      check("mid_rst_ready", 32'(s_ready), 32'(0));
      wrst_n = 1'b1;
      tick();
      check("mid_rst_busy", 32'(s_busy), 32'(0));
      check("mid_rst_gid", 32'(s_gid), 32'(0));
      req_valid = '0;
      tick();
      do_reset();

      check("sb_drained", 32'(exp_q.size()), 32'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares the asynchronous FIFO write port between `NUM_REQ` independent requesters in the write clock domain. Each requester presents data on a valid/ready handshake. The arbiter grants one requester at a time for a burst of up to `BURST_LEN` beats and drives `winc`/`wdata` into the FIFO write side. It honours `wfull` so that no write is ever issued while the FIFO is full.

## Interface
Parameters:
- `DSIZE`, 8: data width per beat.
- `NUM_REQ`, 4: number of requesters, range 2..8.
- `BURST_LEN`, 4: maximum beats per grant, range 1..16.

Ports:
- `wclk` input 1: write-domain clock; all logic is on the rising edge.
- `wrst_n` input 1: reset, synchronous, active-low.
- `req_valid` input `NUM_REQ`: bit i means requester i has a beat.
- `req_data` input `NUM_REQ*DSIZE`: requester i data in bits `[i*DSIZE +: DSIZE]`.
- `req_ready` output `NUM_REQ`: bit i means the beat from requester i is accepted this cycle.
- `wfull` input 1: FIFO full flag from the write-side pointer logic.
- `winc` output 1: FIFO write enable.
- `wdata` output `DSIZE`: FIFO write data.
- `grant_id` output `$clog2(NUM_REQ)`: index of the current or last granted requester.
- `busy` output 1: high while a grant is held.

## Operation
- State machine has two states, IDLE and GRANT. Registered state: `state`, `gnt` (= `grant_id`), `rr_ptr`, `beat_cnt` (`$clog2(BURST_LEN)+1` bits).
- **IDLE**
  - If any `req_valid` is set, pick the first set bit scanning upward from `rr_ptr`, wrapping modulo `NUM_REQ`.
  - Next cycle: `gnt` = pick, `beat_cnt` = 0, `state` = GRANT.
  - No transfer occurs in IDLE.
- **GRANT: handshake**
  - `accept = req_valid[gnt] & ~wfull & wrst_n`.
  - `req_ready[gnt] = ~wfull & wrst_n`. All other `req_ready` bits are 0.
  - `winc = accept`.
  - `wdata = req_data[gnt]`. `wdata` is 0 when not in GRANT.
- **GRANT: release.** Go to IDLE with `rr_ptr = (gnt+1) mod NUM_REQ` when either:
  - `accept` is high and `beat_cnt == BURST_LEN-1` (counter otherwise increments on each `accept`), or
  - `req_valid[gnt]` is low. This applies even while `wfull` is high.
- **`wfull` stall:** grant is held, `beat_cnt` is frozen, and there is no timeout.
- **Requester rule:** `req_data` must stay stable while `req_valid` is high and `req_ready` is low. The arbiter does not check this.
- **Non-granted requesters:** they see `req_ready` = 0 and must hold their data.
- **Round-robin state:** `rr_ptr` updates only on release, so an early release (valid drop) still rotates priority.
- `busy = (state == GRANT)`.

## Timing
- **Reset values** (sampled at a `wclk` edge with `wrst_n` = 0):
  - `state` = IDLE, `gnt` = 0, `rr_ptr` = 0, `beat_cnt` = 0.
  - Outputs: `winc` = 0, `req_ready` = 0, `wdata` = 0, `grant_id` = 0, `busy` = 0.
- **During a reset cycle:** `winc` and `req_ready` are gated low combinationally, so no write occurs in the cycle `wrst_n` is low, even if `state` is still GRANT.
- **Reset mid-burst:** the burst is abandoned with no partial-state carry-over.
- **Latency:**
  - 1 cycle from `req_valid` rising in IDLE to the first possible `accept`.
  - The data path is combinational (`req_data` to `wdata` within the same cycle).
  - After each release there is exactly one IDLE bubble cycle before the next grant.
- **Peak throughput:** `BURST_LEN` beats per `BURST_LEN+1` cycles.
- **`wfull` timing:** `wfull` is used combinationally within the same cycle. A `wfull` rising in cycle t blocks the write in cycle t.

## Configuration
- Macro: `FIFO_ARB_BURST_EN`.
- **Defined:** the burst behaviour above applies, with up to `BURST_LEN` beats per grant.
- **Undefined:** the effective burst length is 1.
  - Every `accept` releases the grant.
  - `beat_cnt` is not implemented.
  - Strict per-beat round-robin applies, with one IDLE cycle between beats.
  - The `BURST_LEN` parameter is ignored.

## Test plan
- **Reset:** hold `wrst_n` = 0 for 3 cycles with all `req_valid` = 1111.
  - Required: `winc` = 0 and `req_ready` = 0 throughout.
  - After release, the first grant goes to `grant_id` = 0.
- **Round-robin fairness:** all 4 requesters continuously valid, `BURST_LEN` = 4, macro defined.
  - Required grant order 0, 1, 2, 3, 0, with 4 beats each.
  - Required spacing: 5 cycles per grant.
  - 16 FIFO writes in 20 cycles after the first grant.
- **Full stall:** requester 2 granted; assert `wfull` for 6 cycles after beat 1.
  - Required: `winc` = 0 and `req_ready[2]` = 0 during the stall.
  - Grant is held and `wdata` equals `req_data[2]`.
  - Beats 2–4 complete after `wfull` falls.
- **Early release:** requester 1 drops `req_valid` after 2 beats while requester 3 is valid.
  - Required: return to IDLE in the next cycle, then `grant_id` = 3 (not 2).
  - `rr_ptr` = 2 at the time of that pick.
- **Reset mid-burst:** assert `wrst_n` = 0 on beat 3 of requester 1's grant.
  - Required: no `winc` in that cycle; `busy` = 0 and `grant_id` = 0 next cycle.
- **Macro undefined:** requesters 0 and 1 continuously valid.
  - Required grants alternate 0, 1, 0, 1 with one beat each and one write every 2 cycles.
